// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants: PC select codes, opcodes, NOP, fetch FSM states
package riscv_pkg;

    // PC_Control encodings driven by the control unit
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_PLUS4  = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read bus between fetch unit and memory
// master: fetch unit (drives imem_req/imem_addr, receives imem_rvalid/imem_rdata)
// slave : instruction memory
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC target mux with misalignment flag
// in : pc, fetch_pc, pc_control, imm, alu_result
// out: next_pc (target address), misaligned (next_pc[1:0] != 0)
module pc_next_logic
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [1:0]      pc_control,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = fetch_pc;
        case (pc_control)
            PC_HOLD:   next_pc = fetch_pc;
            PC_PLUS4:  next_pc = pc + XLEN'(4);
            PC_BRANCH: next_pc = pc + imm;
            // JALR clears bit 0 of the computed target
            PC_JALR:   next_pc = alu_result & ~XLEN'(1);
            default:   next_pc = fetch_pc;
        endcase
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem read sequencing, instruction register
// in : clk, rst (sync active-high), fetch, PC_Control, imm, alu_result, imem.imem_rvalid/imem_rdata
// out: imem.imem_req/imem_addr, instr and decoded fields, pc, pc_plus4, instr_valid, busy, fetch_err
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch,
    input  logic [1:0]       PC_Control,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  alu_result,
    fetch_unit_if.master     imem,
    output logic [31:0]      instr,
    output logic [6:0]       OPC,
    output logic [2:0]       Func3,
    output logic [6:0]       Func7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             instr_valid,
    output logic             busy,
    output logic             fetch_err
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    // count value whose increment reaches TIMEOUT
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            timeout_hit;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc         (pc_q),
        .fetch_pc   (fetch_pc_q),
        .pc_control (PC_Control),
        .imm        (imm),
        .alu_result (alu_result),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic; rvalid takes priority over the timeout on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: if (fetch) state_d = next_misaligned ? FETCH_ERR : FETCH_REQ;
            FETCH_REQ: begin
                if (imem.imem_rvalid)  state_d = FETCH_IDLE;
                else if (timeout_hit)  state_d = FETCH_ERR;
            end
            FETCH_ERR:  state_d = FETCH_ERR;
            default:    state_d = FETCH_IDLE;
        endcase
    end

    // output / datapath logic
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        req_d      = req_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            FETCH_IDLE: begin
                fetch_pc_d = next_pc;
                if (fetch) begin
                    if (next_misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = next_pc;
                        req_d  = 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            FETCH_REQ: begin
                if (imem.imem_rvalid) begin
                    instr_d = imem.imem_rdata;
                    pc_d    = addr_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (timeout_hit) begin
                        req_d = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= NOP_INSTR;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign OPC            = instr_q[6:0];
    assign rd             = instr_q[11:7];
    assign Func3          = instr_q[14:12];
    assign rs1            = instr_q[19:15];
    assign rs2            = instr_q[24:20];
    assign Func7          = instr_q[31:25];
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign instr_valid    = valid_q;
    assign busy           = (state_q == FETCH_REQ);
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch;
    logic [1:0]  pc_ctl;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: architectural PC and the pending fetch address
    logic [31:0] m_pc;
    logic [31:0] m_fetch_pc;

    fetch_unit_if #(.XLEN(32)) mem_if ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fetch),
        .PC_Control  (pc_ctl),
        .imm         (imm),
        .alu_result  (alu_result),
        .imem        (mem_if),
        .instr       (instr),
        .OPC         (opc),
        .Func3       (func3),
        .Func7       (func7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] target(input logic [1:0] c, input logic [31:0] im,
                                           input logic [31:0] alu);
        case (c)
            2'd0:    return m_fetch_pc;
            2'd1:    return m_pc + 32'd4;
            2'd2:    return m_pc + im;
            default: return {alu[31:1], 1'b0};
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        fetch = 1'b0;
        pc_ctl = 2'd0;
        mem_if.imem_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        m_pc = 32'h0;
        m_fetch_pc = 32'h0;
    endtask

    // one fetch; lat = cycles from fetch edge to rvalid edge; noisy drives ignored inputs during REQ
    task automatic fetch_txn(input logic [1:0] c, input logic [31:0] im, input logic [31:0] alu,
                             input int lat, input logic [31:0] w, input bit noisy);
        logic [31:0] tgt;
        tgt = target(c, im, alu);
        fetch = 1'b1; pc_ctl = c; imm = im; alu_result = alu;
        tick();
        fetch = 1'b0; pc_ctl = 2'd0;
        m_fetch_pc = tgt;
        if (tgt[1:0] != 2'b00) begin
            chk("misalign_err", 32'(fetch_err), 32'd1);
            chk("misalign_req", 32'(mem_if.imem_req), 32'd0);
            chk("misalign_busy", 32'(busy), 32'd0);
            return;
        end
        chk("req_hi", 32'(mem_if.imem_req), 32'd1);
        chk("req_addr", mem_if.imem_addr, tgt);
        chk("busy_hi", 32'(busy), 32'd1);
        for (int i = 1; i < lat; i++) begin
            if (noisy) begin
                fetch = 1'($urandom); pc_ctl = 2'($urandom);
                imm = $urandom; alu_result = $urandom;
            end
            tick();
            chk("req_hold", 32'(mem_if.imem_req), 32'd1);
            chk("addr_hold", mem_if.imem_addr, tgt);
            chk("no_valid_wait", 32'(instr_valid), 32'd0);
        end
        fetch = 1'b0; pc_ctl = 2'd0;
        mem_if.imem_rvalid = 1'b1; mem_if.imem_rdata = w;
        tick();
        mem_if.imem_rvalid = 1'b0; mem_if.imem_rdata = $urandom;
        m_pc = tgt;
        chk("valid_pulse", 32'(instr_valid), 32'd1);
        chk("instr", instr, w);
        chk("opc", 32'(opc), 32'(w[6:0]));
        chk("rd", 32'(rd), 32'(w[11:7]));
        chk("func3", 32'(func3), 32'(w[14:12]));
        chk("rs1", 32'(rs1), 32'(w[19:15]));
        chk("rs2", 32'(rs2), 32'(w[24:20]));
        chk("func7", 32'(func7), 32'(w[31:25]));
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("req_lo", 32'(mem_if.imem_req), 32'd0);
        chk("busy_lo", 32'(busy), 32'd0);
        chk("err_lo", 32'(fetch_err), 32'd0);
        tick();
        chk("valid_once", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  c;
        logic [31:0] im, alu, tgt, r;

        rst = 1'b1; fetch = 1'b0; pc_ctl = 2'd0; imm = '0; alu_result = '0;
        mem_if.imem_rvalid = 1'b0; mem_if.imem_rdata = '0;
        m_pc = 32'h0; m_fetch_pc = 32'h0;
        do_reset();

        // reset values
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opc", 32'(opc), 32'h13);
        chk("rst_fields", {15'd0, func3, func7, rd, rs1, rs2}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_addr", mem_if.imem_addr, 32'h0);
        chk("rst_req", 32'(mem_if.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // directed target cases
        fetch_txn(2'd0, 32'd0, 32'd0, 1, 32'h0000_0033, 1'b0);
        chk("first_pc", pc, 32'h0);
        fetch_txn(2'd1, 32'd0, 32'd0, 1, 32'h0000_0013, 1'b0);
        chk("plus4_pc", pc, 32'h4);
        chk("plus4_link", pc_plus4, 32'h8);
        fetch_txn(2'd1, 32'd0, 32'd0, 2, 32'h0010_0093, 1'b0);
        fetch_txn(2'd1, 32'd0, 32'd0, 1, 32'h0020_0113, 1'b0);
        fetch_txn(2'd1, 32'd0, 32'd0, 1, 32'h0030_0193, 1'b0);
        chk("setup_pc10", pc, 32'h10);
        fetch_txn(2'd2, 32'hFFFF_FFF8, 32'd0, 1, 32'hFE00_0EE3, 1'b0);
        chk("branch_pc", pc, 32'h8);
        fetch_txn(2'd3, 32'd0, 32'h21, 3, 32'h0000_8067, 1'b1);
        chk("jalr_pc", pc, 32'h20);
        fetch_txn(2'd3, 32'd0, 32'hFFFF_FFFD, 1, 32'h0000_0013, 1'b0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_link_wrap", pc_plus4, 32'h0);
        fetch_txn(2'd1, 32'd0, 32'd0, 1, 32'h4000_D2B3, 1'b0);
        chk("wrap_pc", pc, 32'h0);
        // rvalid on the timeout edge wins
        fetch_txn(2'd0, 32'd0, 32'd0, 16, 32'h1234_5037, 1'b0);
        chk("late_ok_pc", pc, 32'h0);

        // misaligned branch target
        fetch_txn(2'd2, 32'd2, 32'd0, 1, 32'h0, 1'b0);
        fetch = 1'b1; pc_ctl = 2'd1;
        mem_if.imem_rvalid = 1'b1;
        tick();
        fetch = 1'b0; mem_if.imem_rvalid = 1'b0;
        chk("err_sticky", 32'(fetch_err), 32'd1);
        chk("err_no_req", 32'(mem_if.imem_req), 32'd0);
        chk("err_no_valid", 32'(instr_valid), 32'd0);
        do_reset();
        chk("misalign_cleared", 32'(fetch_err), 32'd0);

        // timeout: memory silent for 16 cycles
        fetch = 1'b1; pc_ctl = 2'd0;
        tick();
        fetch = 1'b0;
        chk("to_req", 32'(mem_if.imem_req), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_waiting", {30'd0, mem_if.imem_req, fetch_err}, 32'd2);
        end
        tick();
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req_drop", 32'(mem_if.imem_req), 32'd0);
        chk("to_busy_drop", 32'(busy), 32'd0);
        do_reset();
        chk("to_cleared", 32'(fetch_err), 32'd0);

        // reset during REQ, rvalid arriving just after reset
        fetch_txn(2'd1, 32'd0, 32'd0, 1, 32'h0000_0033, 1'b0);
        fetch = 1'b1; pc_ctl = 2'd1;
        tick();
        fetch = 1'b0; pc_ctl = 2'd0;
        chk("midreq_busy", 32'(busy), 32'd1);
        do_reset();
        chk("midreq_req", 32'(mem_if.imem_req), 32'd0);
        chk("midreq_nop", instr, 32'h0000_0013);
        mem_if.imem_rvalid = 1'b1; mem_if.imem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_if.imem_rvalid = 1'b0;
        chk("late_rvalid_drop", 32'(instr_valid), 32'd0);
        chk("late_instr_nop", instr, 32'h0000_0013);
        chk("late_pc", pc, 32'h0);
        chk("late_busy", 32'(busy), 32'd0);

        // randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            c = 2'($urandom);
            r = $urandom;
            im = {{20{r[11]}}, r[11:2], 2'b00};
            alu = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 9) == 0) begin
                im[1] = 1'b1;
                alu[1] = 1'b1;
            end
            tgt = target(c, im, alu);
            fetch_txn(c, im, alu, int'($urandom_range(1, 5)), $urandom, 1'($urandom));
            if (tgt[1:0] != 2'b00) begin
                do_reset();
                chk("rand_err_cleared", 32'(fetch_err), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
